// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encodings, default clocking and the bit-period derivation
// (also intended for the future receiver).
package uart_tx_pkg;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_BAUD     = 115_200;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Clocks per bit, truncated toward zero
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level handshake between the buffered TX stage (master) and the transmitter (slave).
interface uart_tx_if;

   logic       txStart;
   logic [7:0] txData;
   logic       txBusy;
   logic       txDone;

   modport master (output txStart, txData, input txBusy, txDone);
   modport slave  (input txStart, txData, output txBusy, txDone);

endinterface

// File: rtl/uart_baud_tick.sv
// Clear-able bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last count as a bit boundary.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8-bit LSB-first UART transmitter, 1 start bit, 1-2 stop bits, idle-high registered line.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLK_FREQ     = DEF_CLK_FREQ,
   parameter int BAUD         = DEF_BAUD,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus,
   output logic     tx
);

   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_tx: unsupported parameter set");
   end

   state_t     state, state_n;
   logic [7:0] shreg, shreg_n;
   logic [2:0] idx, idx_n;
   logic       busy, busy_n;
   logic       done, done_n;
   logic       tx_n;
   logic       clr;
   logic       tick;

`ifdef UART_TX_PARITY_EN
   logic [7:0] lat, lat_n;
   logic       par_bit;

   // Parity comes from the accepted byte; the shift register has been consumed by now
   assign par_bit = (PARITY_ODD != 0) ? ~^lat : ^lat;
`endif

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      idx_n   = idx;
      busy_n  = busy;
      done_n  = 1'b0;
      tx_n    = tx;
      clr     = 1'b0;
`ifdef UART_TX_PARITY_EN
      lat_n   = lat;
`endif
      case (state)
         IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (bus.txStart) begin
               shreg_n = bus.txData;
`ifdef UART_TX_PARITY_EN
               lat_n   = bus.txData;
`endif
               busy_n  = 1'b1;
               tx_n    = 1'b0;
               idx_n   = 3'd0;
               clr     = 1'b1;
               state_n = START;
            end
         end
         START: begin
            if (tick) begin
               tx_n    = shreg[0];
               shreg_n = {1'b0, shreg[7:1]};
               state_n = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               if (idx == 3'd7) begin
                  idx_n = 3'd0;
`ifdef UART_TX_PARITY_EN
                  tx_n    = par_bit;
                  state_n = PARITY;
`else
                  tx_n    = 1'b1;
                  state_n = STOP;
`endif
               end else begin
                  tx_n    = shreg[0];
                  shreg_n = {1'b0, shreg[7:1]};
                  idx_n   = idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               tx_n    = 1'b1;
               idx_n   = 3'd0;
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               // idx counts stop bits here; the last boundary releases the line
               if (idx == STOP_LAST) begin
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  idx_n = idx + 3'd1;
               end
            end
         end
         default: begin
            tx_n    = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         lat   <= '0;
`endif
      end else begin
         state <= state_n;
         shreg <= shreg_n;
         idx   <= idx_n;
         busy  <= busy_n;
         done  <= done_n;
         tx    <= tx_n;
`ifdef UART_TX_PARITY_EN
         lat   <= lat_n;
`endif
      end
   end

   assign bus.txBusy = busy;
   assign bus.txDone = done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (fast 1-stop, slow 2-stop odd-parity) against a frame model.
module tb_uart_tx;

   localparam int CPB_A  = 4;
   localparam int STOP_A = 1;
   localparam int ODD_A  = 0;
   localparam int CPB_B  = 434;
   localparam int STOP_B = 2;
   localparam int ODD_B  = 1;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tx_a, tx_b;
   int   compared   = 0;
   int   mismatched = 0;

   uart_tx_if ifa ();
   uart_tx_if ifb ();

   uart_tx #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(STOP_A), .PARITY_ODD(ODD_A)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave),
      .tx  (tx_a)
   );

   uart_tx #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(STOP_B), .PARITY_ODD(ODD_B)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave),
      .tx  (tx_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line level during bit slot 'slot' of a frame carrying d
   function automatic logic exp_level(input logic [7:0] d, input int slot, input int odd);
      int ones;
      ones = $countones(d);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return d[3'(slot - 1)];
      if (P == 1 && slot == 9) return 1'((ones + odd) % 2);
      return 1'b1;
   endfunction

   task automatic drive(input bit sel, input logic start, input logic [7:0] d);
      if (sel) begin
         ifb.txStart = start;
         ifb.txData  = d;
      end else begin
         ifa.txStart = start;
         ifa.txData  = d;
      end
   endtask

   task automatic idle(input bit sel, input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check({tag, "/idle_tx"},   sel ? tx_b : tx_a, 1'b1);
         check({tag, "/idle_busy"}, sel ? ifb.txBusy : ifa.txBusy, 1'b0);
         check({tag, "/idle_done"}, sel ? ifb.txDone : ifa.txDone, 1'b0);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the txDone cycle.
   // poke >= 0 pulses txStart with 0xFF during that cycle of the frame.
   task automatic frame(input bit sel, input logic [7:0] d, input int poke, input string tag);
      int cpb, odd, n;
      cpb = sel ? CPB_B : CPB_A;
      odd = sel ? ODD_B : ODD_A;
      n   = (1 + 8 + P + (sel ? STOP_B : STOP_A)) * cpb;
      drive(sel, 1'b1, d);
      @(negedge clk);
      drive(sel, 1'b0, 8'($urandom));
      for (int k = 0; k < n; k++) begin
         check({tag, "/tx"},   sel ? tx_b : tx_a, exp_level(d, k / cpb, odd));
         check({tag, "/busy"}, sel ? ifb.txBusy : ifa.txBusy, 1'b1);
         check({tag, "/done"}, sel ? ifb.txDone : ifa.txDone, 1'b0);
         if (k == poke) drive(sel, 1'b1, 8'hFF);
         else           drive(sel, 1'b0, 8'($urandom));
         @(negedge clk);
      end
      check({tag, "/end_busy"}, sel ? ifb.txBusy : ifa.txBusy, 1'b0);
      check({tag, "/end_done"}, sel ? ifb.txDone : ifa.txDone, 1'b1);
      check({tag, "/end_tx"},   sel ? tx_b : tx_a, 1'b1);
      drive(sel, 1'b0, 8'($urandom));
   endtask

   initial begin
      int nA;
      logic [7:0] rd;
      nA = (1 + 8 + P + STOP_A) * CPB_A;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);

      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      check("rst_tx_a",   tx_a, 1'b1);
      check("rst_busy_a", ifa.txBusy, 1'b0);
      check("rst_done_a", ifa.txDone, 1'b0);
      check("rst_tx_b",   tx_b, 1'b1);
      check("rst_busy_b", ifb.txBusy, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(0, 3, "post_rst");

      // Basic frame
      frame(0, 8'h55, -1, "t1_55");
      idle(0, 4, "t1");

      // txStart while busy, mid-frame and on the final stop clock
      frame(0, 8'h3C, 13, "t2_mid");
      idle(0, 5, "t2_mid");
      frame(0, 8'hC3, nA - 1, "t2_last");
      idle(0, 5, "t2_last");

      // Back-to-back with one idle cycle between frames
      frame(0, 8'h41, -1, "t3_41");
      frame(0, 8'h42, -1, "t3_42");
      frame(0, 8'h43, -1, "t3_43");
      idle(0, 3, "t3");

      // Reset during data bit 3 of 0xA5
      drive(0, 1'b1, 8'hA5);
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      repeat (4 * CPB_A + 1) @(negedge clk);
      check("t4_pre_tx", tx_a, 1'b0);
      #1 rst = 1'b1;
      #1;
      check("t4_async_tx",   tx_a, 1'b1);
      check("t4_async_busy", ifa.txBusy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      idle(0, 3, "t4");
      frame(0, 8'hA5, -1, "t4_clean");
      idle(0, 2, "t4_clean");

      // Random bytes, random pokes, random gaps
      for (int i = 0; i < 8; i++) begin
         rd = 8'($urandom);
         frame(0, rd, int'($urandom_range(0, nA - 1)), "rnd");
         if ($urandom_range(0, 1) == 1) idle(0, int'($urandom_range(1, 3)), "rnd");
      end
      idle(0, 2, "rnd_end");

      // Parity sense on 0x07 (even on A, odd on B), 2 stop bits at 434 clocks/bit
      frame(0, 8'h07, -1, "t5_a07");
      idle(0, 2, "t5_a07");
      frame(1, 8'h00, -1, "t6_b00");
      idle(1, 3, "t6_b00");
      frame(1, 8'h07, 1500, "t5_b07");
      idle(1, 3, "t5_b07");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
